uart_tx_serializer: RTL and testbench

//  Serial UART transmitter directly downstream of the ATC controller's reply path.

---
 rtl/uart_tx_serializer_if.sv | 31 +++
 rtl/uart_tx_serializer.sv | 137 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Reply-word bus between the ATC controller (master) and the UART transmitter (slave).
// Handshake: a word is accepted on a rising clock edge where uart_tx_send and uart_tx_ready are both high;
// uart_tx_data is sampled only on that edge, and a send seen while uart_tx_ready is low is dropped.
interface uart_tx_serializer_if #(
   parameter int DATA_BITS = 9
);
   logic [DATA_BITS-1:0] uart_tx_data;
   logic                 uart_tx_send;
   logic                 uart_tx_ready;
   logic                 tx_serial;
   logic                 tx_done;
   logic [2:0]           tx_state;

   modport master (
      output uart_tx_data,
      output uart_tx_send,
      input  uart_tx_ready,
      input  tx_serial,
      input  tx_done,
      input  tx_state
   );

   modport slave (
      input  uart_tx_data,
      input  uart_tx_send,
      output uart_tx_ready,
      output tx_serial,
      output tx_done,
      output tx_state
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter for 9-bit ATC reply words: start, 9 data bits LSB-first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit (12-bit frame instead of 11).
module uart_tx_serializer #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 9
) (
   input logic                clock,
   input logic                reset_n,
   uart_tx_serializer_if.slave bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   logic bit_end;
   assign bit_end = (baud_q == CNT_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // tx_d is the value the line takes for the next bit, so tx_serial only moves on bit boundaries.
   always_comb begin
      state_d  = state_q;
      baud_d   = bit_end ? '0 : baud_q + CNT_W'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (bus.uart_tx_send) begin
               shift_d  = bus.uart_tx_data;
`ifdef UART_TX_PARITY_EN
               parity_d = ^bus.uart_tx_data;
`endif
               bit_d    = '0;
               tx_d     = 1'b0;
               state_d  = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 4'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            baud_d  = '0;
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.uart_tx_ready = (state_q == S_IDLE);
   assign bus.tx_serial     = tx_q;
   assign bus.tx_done       = (state_q == S_STOP) && bit_end;
   assign bus.tx_state      = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer with CLKS_PER_BIT=4; the line is compared cycle by cycle
// against a frame model built from start/data/parity/stop bit positions.
module tb_uart_tx_serializer;

   localparam int N = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit HAS_PARITY = 1'b1;
   localparam int FB = 12;
`else
   localparam bit HAS_PARITY = 1'b0;
   localparam int FB = 11;
`endif
   localparam int F = FB * N;

   logic clock;
   logic reset_n;
   int   errors;
   int   checks;
   logic [11:0] frame_bits;

   uart_tx_serializer_if #(.DATA_BITS(9)) bus ();

   uart_tx_serializer #(.CLKS_PER_BIT(N), .DATA_BITS(9)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected line level k cycles after the accept edge, from bit position alone.
   function automatic logic model_bit(input logic [8:0] w, input int k);
      int b;
      b = k / N;
      if (b == 0) return 1'b0;
      if (b <= 9) return w[b-1];
      if (HAS_PARITY && b == 10) return ^w;
      return 1'b1;
   endfunction

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         checks++;
         if ({bus.tx_serial, bus.uart_tx_ready, bus.tx_done} !== 3'b110) begin
            errors++;
            $display("FAIL %s idle cycle %0d: {line,ready,done}=%b expected 110", tag, i,
                     {bus.tx_serial, bus.uart_tx_ready, bus.tx_done});
         end
      end
   endtask

   // Starts at the cycle before the accept edge, ends on the last cycle of the stop bit.
   task automatic run_frame(input logic [8:0] w, input int inject_at, input logic [8:0] inj_w,
                            input string tag);
      logic exp_line;
      @(negedge clock);
      checks++;
      if ({bus.tx_serial, bus.uart_tx_ready, bus.tx_done} !== 3'b110) begin
         errors++;
         $display("FAIL %s pre-accept: {line,ready,done}=%b expected 110", tag,
                  {bus.tx_serial, bus.uart_tx_ready, bus.tx_done});
      end
      bus.uart_tx_data = w;
      bus.uart_tx_send = 1'b1;
      @(posedge clock);
      #1;
      bus.uart_tx_send = 1'b0;
      bus.uart_tx_data = 9'($urandom);
      frame_bits = '0;
      for (int k = 0; k < F; k++) begin
         @(negedge clock);
         exp_line = model_bit(w, k);
         if ((k % N) == N / 2) frame_bits[k/N] = bus.tx_serial;
         checks++;
         if (bus.tx_serial !== exp_line) begin
            errors++;
            $display("FAIL %s line k=%0d: got %b expected %b", tag, k, bus.tx_serial, exp_line);
         end
         checks++;
         if (bus.uart_tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready k=%0d: got %b expected 0", tag, k, bus.uart_tx_ready);
         end
         checks++;
         if (bus.tx_done !== (k == F - 1)) begin
            errors++;
            $display("FAIL %s tx_done k=%0d: got %b expected %b", tag, k, bus.tx_done, (k == F - 1));
         end
         if (k == inject_at) begin
            bus.uart_tx_send = 1'b1;
            bus.uart_tx_data = inj_w;
         end else if (k == inject_at + 1) begin
            bus.uart_tx_send = 1'b0;
            bus.uart_tx_data = 9'($urandom);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.uart_tx_send = 1'b0;
      bus.uart_tx_data = '0;
      #23;
      checks++;
      if ({bus.tx_serial, bus.uart_tx_ready, bus.tx_done} !== 3'b110) begin
         errors++;
         $display("FAIL reset values: {line,ready,done}=%b expected 110",
                  {bus.tx_serial, bus.uart_tx_ready, bus.tx_done});
      end
      @(negedge clock);
      reset_n = 1'b1;
      idle_cycles(10, "reset_idle");
   endtask

   task automatic test_known_word();
      logic [11:0] exp_bits;
      run_frame(9'h1A5, -10, 9'h000, "word_1A5");
      exp_bits = HAS_PARITY ? {1'b1, 1'b1, 9'h1A5, 1'b0} : {1'b0, 1'b1, 9'h1A5, 1'b0};
      checks++;
      if (frame_bits !== exp_bits) begin
         errors++;
         $display("FAIL word_1A5 bits: got %b expected %b", frame_bits, exp_bits);
      end
      idle_cycles(1, "after_1A5");
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      run_frame(9'h1A5, -10, 9'h000, "parity_1A5");
      checks++;
      if (frame_bits[10] !== 1'b1) begin
         errors++;
         $display("FAIL parity_1A5 bit: got %b expected 1", frame_bits[10]);
      end
      idle_cycles(2, "after_parity_1A5");
      run_frame(9'h003, -10, 9'h000, "parity_003");
      checks++;
      if (frame_bits[10] !== 1'b0) begin
         errors++;
         $display("FAIL parity_003 bit: got %b expected 0", frame_bits[10]);
      end
      idle_cycles(2, "after_parity_003");
   endtask
`endif

   task automatic test_ignored_send();
      run_frame(9'h0FF, 17, 9'h100, "ignored_send");
      idle_cycles(2 * N, "no_queued_frame");
   endtask

   task automatic test_back_to_back();
      idle_cycles(3, "pre_b2b");
      run_frame(9'h155, -10, 9'h000, "b2b_first");
      run_frame(9'h0AA, -10, 9'h000, "b2b_second");
      idle_cycles(2, "post_b2b");
   endtask

   task automatic test_random();
      logic [8:0] w;
      int gap;
      for (int i = 0; i < 8; i++) begin
         w   = 9'($urandom);
         gap = $urandom_range(0, 3);
         run_frame(w, -10, 9'h000, $sformatf("random_%0d", i));
         if (gap > 0) idle_cycles(gap, "random_gap");
      end
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clock);
      bus.uart_tx_data = 9'h1A5;
      bus.uart_tx_send = 1'b1;
      @(posedge clock);
      #1;
      bus.uart_tx_send = 1'b0;
      // Cycle 20 is the first cycle of data bit 4.
      repeat (21) @(negedge clock);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.tx_serial, bus.uart_tx_ready, bus.tx_done} !== 3'b110) begin
         errors++;
         $display("FAIL reset_mid_frame: {line,ready,done}=%b expected 110",
                  {bus.tx_serial, bus.uart_tx_ready, bus.tx_done});
      end
      @(negedge clock);
      reset_n = 1'b1;
      idle_cycles(2, "after_mid_reset");
      run_frame(9'h001, -10, 9'h000, "post_reset_001");
      idle_cycles(2, "end");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_known_word();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_ignored_send();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
